seq_shift_add_multiplier: RTL and testbench

Iterative unsigned WIDTH×WIDTH multiplier producing a 2·WIDTH-bit product over WIDTH+1 clock cycles. It is the sequential consumer of the team's 32-bit adder (ports a, b, Cin, S, Cout). It instantiates exactly one adder, drives it with the running partial sum and the gated multiplicand, and registers S/Cout every cycle. It is the area-cheap alternative to the array multipliers, and it is the first clocked block in the arithmetic library.

---
 rtl/seq_shift_add_multiplier.sv | 102 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned WIDTH x WIDTH shift-and-add multiplier built around one WIDTH-bit adder.
// One partial-product iteration per cycle; result registered at the last iteration edge.

module seq_shift_add_multiplier_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);
   assign {Cout, S} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, Cin};
endmodule

module seq_shift_add_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 hi_nonzero
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] sum;
   logic             cout;

   assign add_b = q[0] ? m_reg : '0;

   seq_shift_add_multiplier_adder #(.WIDTH(WIDTH)) u_adder (
      .a    (acc),
      .b    (add_b),
      .Cin  (1'b0),
      .S    (sum),
      .Cout (cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         m_reg      <= '0;
         acc        <= '0;
         q          <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         product    <= '0;
         hi_nonzero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m_reg <= a;
                  q     <= b;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               // {Cout,S,Q} shifted right by one; the bit falling off Q is already consumed
               acc <= {cout, sum[WIDTH-1:1]};
               q   <= {sum[0], q[WIDTH-1:1]};
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  product    <= {cout, sum, q[WIDTH-1:1]};
                  hi_nonzero <= cout | (|sum[WIDTH-1:1]);
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: stimulus pushes expected products,
// a negedge monitor pops and compares on every done pulse.

module tb_seq_shift_add_multiplier;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   a_i = '0;
   logic [W-1:0]   b_i = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic           hi_nonzero;

   seq_shift_add_multiplier #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a_i),
      .b          (b_i),
      .busy       (busy),
      .done       (done),
      .product    (product),
      .hi_nonzero (hi_nonzero)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int prev_done_cyc = 0;
   bit have_prev = 1'b0;
   bit b2b = 1'b0;
   bit chk_after = 1'b0;
   logic busy_prev = 1'b0;
   logic [2*W:0] hold_ref;
   logic [2*W-1:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: compares every completion against the scoreboard head
   always @(negedge clk) begin
      logic [2*W-1:0] e;
      if (chk_after) begin
         chk("busy_after_done", {64'd0, busy}, '0);
         chk("done_single_cycle", {64'd0, done}, '0);
         chk_after = 1'b0;
      end
      if (busy === 1'b1 && busy_prev !== 1'b1) acc_cyc = cyc;
      busy_prev = busy;
      if (rst) begin
         hold_ref = {hi_nonzero, product};
      end else if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=%h expected=none", product);
         end else begin
            e = exp_q.pop_front();
            chk("product", {1'b0, product}, {1'b0, e});
            chk("hi_nonzero", {64'd0, hi_nonzero}, {64'd0, |e[2*W-1:W]});
            chk("latency", 65'(cyc - acc_cyc), 65'(W));
            if (b2b && have_prev) chk("b2b_spacing", 65'(cyc - prev_done_cyc), 65'(W + 2));
         end
         prev_done_cyc = cyc;
         have_prev = 1'b1;
         hold_ref = {hi_nonzero, product};
         chk_after = 1'b1;
      end else begin
         chk("product_hold", {hi_nonzero, product}, hold_ref);
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit hold);
      int n;
      a_i   = ia;
      b_i   = ib;
      start = 1'b1;
      exp_q.push_back({32'd0, ia} * {32'd0, ib});
      n = 0;
      while (busy && n < 3 * W) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 3 * W) chk("idle_timeout", {64'd0, busy}, '0);
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 3 * W && exp_q.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=pending%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", {64'd0, busy}, '0);
      chk("rst_done", {64'd0, done}, '0);
      chk("rst_product", {1'b0, product}, '0);
      chk("rst_hi", {64'd0, hi_nonzero}, '0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors
      issue(32'd3, 32'd5, 1'b0);                 wait_done();
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done();
      issue(32'd0, 32'h1234_5678, 1'b0);         wait_done();
      issue(32'h8000_0000, 32'd2, 1'b0);         wait_done();
      issue(32'd1, 32'hFFFF_FFFF, 1'b0);         wait_done();

      // Start while busy must be ignored
      issue(32'd7, 32'd6, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      a_i = 32'd9; b_i = 32'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      repeat (2 * W) @(negedge clk);

      // Reset mid-operation
      issue(32'd1234, 32'd5678, 1'b0);
      repeat (14) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort_busy", {64'd0, busy}, '0);
      chk("abort_done", {64'd0, done}, '0);
      chk("abort_product", {1'b0, product}, '0);
      chk("abort_hi", {64'd0, hi_nonzero}, '0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      issue(32'd100, 32'd50, 1'b0);
      wait_done();

      // Back-to-back with start held high
      b2b = 1'b1;
      have_prev = 1'b0;
      for (int i = 0; i < 200; i++) issue(W'($urandom), W'($urandom), 1'b1);
      start = 1'b0;
      wait_done();
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
